// File: rtl/sn74ls31_arb.sv
// Round-robin arbiter that lends one inverting delay element to four requesters and measures its delay.
// Optional timeout per wait phase is compiled in with `define SN74LS31_ARB_TMO_EN (parameter TMO).
module sn74ls31_arb #(
    parameter int TMO = 200
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [3:0] done,
    output logic       a,
    input  logic       y,
    output logic [7:0] dly,
    output logic       err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       y_s1;
    logic       ys;
    logic [7:0] cnt;
    logic [1:0] ptr;
    logic [1:0] gsel;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       any_req;
    logic       tmo_hit;

    // y is asynchronous to clk; only the second flop is ever looked at.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            y_s1 <= 1'b1;
            ys   <= 1'b1;
        end else begin
            y_s1 <= y;
            ys   <= y_s1;
        end
    end

    // Scan downward in priority so the nearest set bit after ptr wins last.
    always_comb begin
        pick    = ptr;
        idx     = 2'd0;
        any_req = |req;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + i[1:0];
            if (req[idx]) pick = idx;
        end
    end

`ifdef SN74LS31_ARB_TMO_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmr;

    // Phase timer restarts whenever the FSM changes state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tmr <= '0;
        end else if (state == IDLE || state != state_nx) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TW'(1);
        end
    end

    assign tmo_hit = (tmr == TW'(TMO - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err <= 1'b0;
        end else if (state == IDLE && any_req) begin
            err <= 1'b0;
        end else if (((state == HIGH && ys) || (state == LOW && !ys)) && tmo_hit) begin
            err <= 1'b1;
        end
    end
`else
    // Timeout disabled: constant false, the phases wait forever.
    assign tmo_hit = (TMO < 0);
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (any_req) state_nx = HIGH;
            HIGH: begin
                if (!ys)          state_nx = LOW;
                else if (tmo_hit) state_nx = DONE;
            end
            LOW: begin
                if (ys)           state_nx = DONE;
                else if (tmo_hit) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        done      = (state == DONE) ? gnt : 4'b0000;
        dbg_state = state;
    end

    // Datapath: grant, delay drive and measurement.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            gnt  <= 4'b0000;
            gsel <= 2'd0;
            a    <= 1'b0;
            cnt  <= 8'd0;
            dly  <= 8'd0;
            ptr  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt  <= 4'b0001 << pick;
                        gsel <= pick;
                        a    <= 1'b1;
                        cnt  <= 8'd0;
                    end
                end
                HIGH: begin
                    if (!ys) begin
                        // The synchroniser lag makes cnt+1 equal to the element delay plus two.
                        dly <= (cnt == 8'hff) ? 8'hff : cnt + 8'd1;
                        a   <= 1'b0;
                        cnt <= 8'd0;
                    end else if (tmo_hit) begin
                        a   <= 1'b0;
                        dly <= 8'hff;
                    end else if (cnt != 8'hff) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                LOW: begin
                    a <= 1'b0;
                end
                DONE: begin
                    gnt <= 4'b0000;
                    ptr <= gsel;
                end
                default: begin
                    gnt <= 4'b0000;
                    a   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn74ls31_arb.sv
// Randomised bench for sn74ls31_arb with a transaction-level round-robin / delay model checked every cycle.
module tb_sn74ls31_arb;

    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [3:0] req;
    logic       y;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       a;
    logic [7:0] dly;
    logic       err;
    logic [1:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;

    int   dly_d;
    logic y_stuck;
    logic hist_clr;
    logic hist [0:511];

    int glog[$];
    int dly_log[$];

    sn74ls31_arb #(.TMO(TMO)) dut (
        .clk(clk), .clr_n(clr_n), .req(req), .gnt(gnt), .done(done),
        .a(a), .y(y), .dly(dly), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Delay element: y is ~a seen dly_d falling edges earlier.
    initial begin
        for (int i = 0; i < 512; i++) hist[i] = 1'b1;
        y = 1'b1;
        forever begin
            @(negedge clk);
            if (hist_clr) begin
                for (int i = 0; i < 512; i++) hist[i] = 1'b1;
            end else begin
                for (int i = 511; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = ~a;
            end
            y = y_stuck ? 1'b1 : hist[dly_d-1];
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        int         m_ptr;
        bit         m_busy;
        int         m_g;
        int         a_cnt;
        int         busy_cyc;
        int         w;
        int         exp_ahigh;
        logic [7:0] m_dly;
        logic [7:0] exp_dly;
        logic [3:0] req_prev;
        bit         after_done;
        m_ptr = 3; m_busy = 0; m_g = 0; a_cnt = 0; busy_cyc = 0;
        m_dly = 8'd0; req_prev = 4'b0000; after_done = 0;
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                chk("rst_gnt", gnt, 0);
                chk("rst_done", done, 0);
                chk("rst_a", a, 0);
                chk("rst_dly", dly, 0);
                chk("rst_err", err, 0);
                m_ptr = 3; m_busy = 0; m_dly = 8'd0; after_done = 0;
            end else begin
                chk("gnt_onehot", ($countones(gnt) <= 1), 1);
                if (after_done) chk("gnt_clear_after_done", gnt, 0);
                after_done = 0;
`ifndef SN74LS31_ARB_TMO_EN
                chk("err_zero", err, 0);
`endif
                if (!m_busy && gnt != 4'b0000) begin
                    w = -1;
                    for (int k = 1; k <= 4; k++)
                        if (w < 0 && req_prev[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                    chk("grant", gnt, (w < 0) ? 0 : (1 << w));
                    chk("a_at_grant", a, 1);
                    for (int k = 0; k < 4; k++) if (gnt[k]) m_g = k;
                    m_busy = 1; a_cnt = 0; busy_cyc = 0;
                    glog.push_back(m_g);
                end else if (!m_busy) begin
                    chk("idle_done", done, 0);
                    chk("idle_dly", dly, m_dly);
                end
                if (m_busy) begin
                    if (a) a_cnt++;
                    busy_cyc++;
                    if (done != 4'b0000) begin
                        exp_ahigh = y_stuck ? TMO : dly_d + 2;
                        exp_dly   = (y_stuck || dly_d + 2 > 255) ? 8'd255 : 8'(dly_d + 2);
                        chk("done_onehot", done, 1 << m_g);
                        chk("done_eq_gnt", done, gnt);
                        chk("a_high_cycles", a_cnt, exp_ahigh);
                        chk("dly", dly, exp_dly);
                        m_dly = exp_dly; m_ptr = m_g; m_busy = 0; after_done = 1;
                        dly_log.push_back(int'(dly));
                    end else if (busy_cyc > 2000 && !y_stuck) begin
                        chk("seq_stalled", busy_cyc, 0);
                        m_busy = 0;
                    end
                end
            end
            req_prev = req;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (done != 4'b0000) return;
        end
        chk("wait_done_timeout", 0, 1);
    endtask

    task automatic wait_grant(input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (gnt != 4'b0000) return;
        end
        chk("wait_grant_timeout", 0, 1);
    endtask

    task automatic go_idle(input int new_d);
        req = 4'b0000;
        for (int i = 0; i < 1000 && gnt != 4'b0000; i++) cyc(1);
        cyc(2);
        hist_clr = 1'b1;
        cyc(1);
        dly_d = new_d;
        hist_clr = 1'b0;
        cyc(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        clr_n = 1'b0; req = 4'b1111; dly_d = 5; y_stuck = 1'b0; hist_clr = 1'b1;
        cyc(8);
        hist_clr = 1'b0; req = 4'b0000; clr_n = 1'b1;
        cyc(3);

        // Single request, D=5.
        req = 4'b0100;
        wait_grant(20);
        chk("single_gnt", gnt, 4'b0100);
        wait_done(100);
        chk("single_done", done, 4'b0100);
        req = 4'b0000;
        cyc(3);
        chk("single_gnt_after", gnt, 4'b0000);
        chk("single_dly_lit", dly, 8'd7);

        // Round-robin from reset.
        clr_n = 1'b0; cyc(3); clr_n = 1'b1; cyc(1);
        glog.delete();
        req = 4'b1111;
        repeat (5) wait_done(100);
        req = 4'b0000;
        cyc(4);
        chk("rr_count", glog.size(), 5);
        if (glog.size() >= 5) begin
            chk("rr_0", glog[0], 0);
            chk("rr_1", glog[1], 1);
            chk("rr_2", glog[2], 2);
            chk("rr_3", glog[3], 3);
            chk("rr_4", glog[4], 0);
        end

        // Withdrawal while HIGH.
        go_idle(5);
        req = 4'b0010;
        wait_grant(20);
        cyc(2);
        chk("wd_a_high", a, 1);
        req = 4'b0000;
        wait_done(100);
        chk("wd_done", done, 4'b0010);
        cyc(3);

        // Randomised segments.
        for (int s = 0; s < 30; s++) begin
            go_idle($urandom_range(1, 12));
            req = 4'($urandom_range(1, 15));
            for (int c = $urandom_range(30, 120); c > 0; c--) begin
                if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
                cyc(1);
            end
        end

        // Reset mid-sequence, then lowest-index active request wins.
        go_idle(5);
        req = 4'b0001;
        wait_grant(20);
        cyc(3);
        clr_n = 1'b0; req = 4'b0110;
        cyc(10);
        clr_n = 1'b1;
        wait_grant(20);
        chk("post_rst_gnt", gnt, 4'b0010);
        wait_done(100);
        req = 4'b0000;
        cyc(3);

        // Saturation: D=300.
        go_idle(300);
        req = 4'b1000;
        wait_grant(20);
        req = 4'b0000;
        wait_done(1500);
        chk("sat_done", done, 4'b1000);
        cyc(2);
        chk("sat_dly_lit", dly, 8'd255);

        // y stuck high.
        go_idle(5);
        y_stuck = 1'b1;
        req = 4'b0001;
        wait_grant(20);
        req = 4'b0000;
`ifdef SN74LS31_ARB_TMO_EN
        begin
            int k;
            k = 0;
            while (a && k < 1000) begin cyc(1); k++; end
            chk("tmo_cycles", k, TMO);
            chk("tmo_err", err, 1);
            chk("tmo_dly", dly, 8'd255);
            wait_done(10);
            chk("tmo_done", done, 4'b0001);
            cyc(2);
        end
`else
        for (int k = 0; k < 40; k++) begin
            cyc(10);
            chk("stuck_a_held", a, 1);
            chk("stuck_gnt_held", gnt, 4'b0001);
        end
        clr_n = 1'b0; cyc(3); clr_n = 1'b1;
`endif
        y_stuck = 1'b0;
        cyc(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sn74ls31_arb.md
SN74LS31_ARB -- requirements
Module: sn74ls31_arb

Interface
REQ-001 SHALL provide parameter TMO, default 200, meaning timeout in clk cycles per wait phase; it is used only when SN74LS31_ARB_TMO_EN is defined.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL provide port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL provide port req, input, 4 bits: level requests for the shared delay element, one bit per requester.
REQ-005 SHALL provide port gnt, output, 4 bits: one-hot grant, held for the whole sequence.
REQ-006 SHALL provide port done, output, 4 bits: one-cycle completion pulse to the granted requester.
REQ-007 SHALL provide port a, output, 1 bit: registered drive to the inverting delay element input.
REQ-008 SHALL provide port y, input, 1 bit: inverted, delayed return from the delay element; asynchronous to clk.
REQ-009 SHALL provide port dly, output, 8 bits: measured a-rise to y-fall delay in clk cycles.
REQ-010 SHALL provide port err, output, 1 bit: timeout flag.

Function
REQ-011 SHALL synchronise y through two flops (ys); all decisions use ys only.
REQ-012 SHALL implement FSM states IDLE, HIGH, LOW and DONE.
REQ-013 IDLE: when any req bit is 1, SHALL grant the first set bit searching upward from ptr+1 modulo 4, set gnt, set a=1, clear cnt, clear err, and enter HIGH on the same edge.
REQ-014 HIGH: a=1; cnt SHALL increment each cycle, saturating at 255; on the first cycle ys==0, SHALL load dly with a value equal to D+2 (D = external delay in whole cycles), set a=0, clear cnt, and enter LOW.
REQ-015 LOW: a=0; when ys==1, SHALL enter DONE.
REQ-016 DONE: SHALL assert done[g] for exactly one cycle, clear gnt, set ptr=g, and return to IDLE; a req arriving in DONE SHALL be served from IDLE on the following cycle.
REQ-017 SHALL complete a sequence, including the done pulse, even if the granted req deasserts mid-sequence.
REQ-018 SHALL keep gnt one-hot or zero at all times; done SHALL be zero or equal to gnt during DONE.
REQ-019 SHALL hold dly until overwritten by the next sequence; D+2 > 255 SHALL yield 255.
REQ-020 Simultaneous requests SHALL be served in strict round-robin order; no requester waits more than 3 sequences.

Reset
REQ-021 clr_n low SHALL immediately force state=IDLE, gnt=0, done=0, a=0, dly=0, err=0, cnt=0, ptr=3, and both sync flops=1.
REQ-022 Reset asserted mid-sequence SHALL abort it with no done pulse; the first grant after release SHALL go to the lowest-index active req.

Configuration
REQ-023 With SN74LS31_ARB_TMO_EN defined, HIGH or LOW lasting TMO cycles without the expected ys level SHALL set err=1, force a=0, set dly=255 when the timeout occurs in HIGH, and enter DONE; err SHALL stay set until the next grant.
REQ-024 Without SN74LS31_ARB_TMO_EN, err SHALL be constant 0, no timeout logic SHALL exist, and HIGH/LOW SHALL wait indefinitely.

Verification
REQ-025 SHALL verify reset: clr_n=0 with req=4'b1111 -> gnt=0, done=0, a=0, dly=0, err=0 throughout.
REQ-026 SHALL verify a single request: y model = ~a delayed 5 cycles, req=4'b0100 -> gnt=4'b0100, a high until ys falls, dly=7, one done[2] pulse, gnt=0 afterwards.
REQ-027 SHALL verify round-robin: req=4'b1111 held -> grant order 0,1,2,3,0 with a single-cycle done for each.
REQ-028 SHALL verify request withdrawal: req[1] dropped in HIGH -> sequence completes and done[1] still pulses once.
REQ-029 SHALL verify timeout with SN74LS31_ARB_TMO_EN defined: y stuck at 1, TMO=200 -> err=1 and a=0 200 cycles after grant, dly=255, done pulses; without the macro, a stays 1 indefinitely.
REQ-030 SHALL verify saturation without the macro: D=300 -> dly=255 and normal completion.
